camera_frame_grabber: RTL
=========================

# camera_frame_grabber

Parametrised OV7670 frame-capture engine between the camera pins (pclk domain) and the frame-buffer write port. It pairs bytes into pixels, converts RGB565 to the buffer format, and decimates by 1, 2 or 4 in both axes. It supports single-shot and continuous capture with start/abort control and frame counting. It reports a sticky overflow flag and a sticky line-sync error flag.

## Interface
- ADDR_WIDTH, 17: frame-buffer word address width; buffer depth is 2^ADDR_WIDTH.
- PIX_WIDTH, 12: output pixel width; 12 = RGB444, 16 = raw RGB565. Other values are illegal.
- DATA_IN_WIDTH, 8: camera data bus width.
- CNT_WIDTH, 10: width of the column and row counters.
- FCNT_WIDTH, 8: width of the frame counter.

Ports:
- pclk  in  1  camera pixel clock, 25 MHz; all logic on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- camera_v_sync  in  1  high = vertical blanking / frame boundary.
- camera_h_ref  in  1  high = valid bytes on din.
- din  in  DATA_IN_WIDTH  camera byte; high byte first.
- start  in  1  one-cycle arm request.
- abort  in  1  one-cycle cancel.
- continuous  in  1  0 = single-shot, 1 = re-arm after every frame; sampled when start is accepted.
- decim  in  2  0 = 1:1, 1 = 1:2, 2 = 1:4, 3 = reserved (treated as 2); sampled when start is accepted.
- addr  out  ADDR_WIDTH  write address.
- dout  out  PIX_WIDTH  write data.
- wr_en  out  1  write strobe.
- busy  out  1  high in ARM and CAPTURE.
- done  out  1  frame complete (see Operation).
- frame_cnt  out  FCNT_WIDTH  count of completed frames, wraps.
- overflow  out  1  sticky: a write was suppressed because the buffer was full.
- sync_err  out  1  sticky: a line ended on an odd byte count.

## Operation
- State machine: IDLE, ARM, CAPTURE.
- IDLE -> ARM on start; this clears done, overflow and sync_err.
- ARM -> CAPTURE on the first cycle with camera_v_sync=0 after at least one cycle of camera_v_sync=1. Entering CAPTURE zeroes the address and the row/column counters.
- CAPTURE -> IDLE on rising camera_v_sync when continuous=0.
- CAPTURE -> ARM on rising camera_v_sync when continuous=1.
- Byte pairing: a byte-phase toggle advances on each cycle with h_ref=1.
  - Phase 0 latches the high byte.
  - Phase 1 forms pixel P={hi,lo}.
  - Phase resets to 0 whenever h_ref=0.
- Format: PIX_WIDTH=12 gives dout={P[15:12],P[10:7],P[4:1]}. PIX_WIDTH=16 gives dout=P.
- Column counter x increments per pixel. Row counter y increments on the falling edge of h_ref and x clears there. Both counters saturate at all-ones.
- Keep rule: with m=(1<<decim)-1, a pixel is written iff (x&m)==0 and (y&m)==0.
- Addressing: first written pixel goes to addr=0, then +1 per write. After the write to 2^ADDR_WIDTH-1, further writes are suppressed and overflow is set; addr holds at max.
- Line error: if h_ref falls while in phase 1, the orphan byte is discarded, sync_err is set and no write occurs.
- Frame end: on rising v_sync in CAPTURE, frame_cnt increments and done is asserted.
  - Single-shot: done is a level held until the next accepted start.
  - Continuous: done is a one-cycle pulse.
- abort in ARM or CAPTURE: go to IDLE; wr_en deasserts from the next edge. done and frame_cnt are unchanged.
- start while busy is ignored. start and abort in the same cycle: abort wins, and from IDLE the block stays in IDLE.
- Reset values: state IDLE; addr 0, dout 0, wr_en 0, busy 0, done 0, frame_cnt 0, overflow 0, sync_err 0. Reset mid-frame discards the partial frame.

## Timing
- Latency: the low byte sampled at edge k produces registered wr_en/addr/dout valid after edge k+1, for exactly one cycle.
- Minimum write spacing is 2 cycles; wr_en is never asserted on consecutive cycles.
- busy rises 1 cycle after start and falls 1 cycle after the terminating v_sync edge or abort.
- done and the frame_cnt increment take effect on the edge after v_sync is sampled high.
- No writes occur while v_sync=1 or outside CAPTURE.

## Test plan
- Single-shot, decim=0, 4x2 frame, bytes 0xF8,0x1F repeated -> 8 writes at addr 0..7, dout=0xF0F each; done=1 held; frame_cnt=1; busy=0.
- decim=1, 8x4 frame -> 8 writes (x∈{0,2,4,6}, y∈{0,2}) at addr 0..7; decim=2, same frame -> 2 writes.
- Continuous, 3 frames of 2x2 -> 3 one-cycle done pulses, frame_cnt=3, addr restarts at 0 each frame.
- ADDR_WIDTH=3, 4x4 frame -> 8 writes to addr 0..7, then overflow=1 with no further wr_en.
- Line of 3 bytes -> one write, sync_err=1; the next line is captured normally.
- Abort mid-line -> wr_en=0 from the next edge, done=0, frame_cnt unchanged; rst_n low mid-frame -> all outputs at reset values asynchronously.

Source files
------------

// File: rtl/camera_frame_grabber.sv
// camera_frame_grabber
//   OV7670 frame-capture engine. Bytes arriving on din while camera_h_ref is
//   high are paired into 16-bit RGB565 pixels (high byte first). Each pixel is
//   optionally converted to RGB444, decimated by 1, 2 or 4 in both axes, and
//   written to a frame buffer at sequential word addresses.
//
// Ports (all synchronous to pclk except rst_n):
//   pclk, rst_n              clock, asynchronous active-low reset
//   camera_v_sync            high = vertical blanking / frame boundary
//   camera_h_ref             high = valid byte on din
//   din                      camera byte, high byte first
//   start, abort             one-cycle arm / cancel requests
//   continuous, decim        capture mode, sampled when start is accepted
//   addr, dout, wr_en        frame-buffer write port (registered)
//   busy                     high in ARM and CAPTURE
//   done                     frame complete: level (single-shot) or pulse (continuous)
//   frame_cnt                completed frames, wraps
//   overflow, sync_err       sticky status, cleared by an accepted start
module camera_frame_grabber #(
  parameter int ADDR_WIDTH    = 17,
  parameter int PIX_WIDTH     = 12,
  parameter int DATA_IN_WIDTH = 8,
  parameter int CNT_WIDTH     = 10,
  parameter int FCNT_WIDTH    = 8
) (
  input  logic                     pclk,
  input  logic                     rst_n,
  input  logic                     camera_v_sync,
  input  logic                     camera_h_ref,
  input  logic [DATA_IN_WIDTH-1:0] din,
  input  logic                     start,
  input  logic                     abort,
  input  logic                     continuous,
  input  logic [1:0]               decim,
  output logic [ADDR_WIDTH-1:0]    addr,
  output logic [PIX_WIDTH-1:0]     dout,
  output logic                     wr_en,
  output logic                     busy,
  output logic                     done,
  output logic [FCNT_WIDTH-1:0]    frame_cnt,
  output logic                     overflow,
  output logic                     sync_err
);

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_CAPTURE} state_e;

  state_e state_q, state_d;

  logic                     vs_q;
  logic                     seen_vs_q;
  logic                     cont_q;
  logic [1:0]               decim_q;
  logic                     done_q;
  logic [FCNT_WIDTH-1:0]    fcnt_q;
  logic                     ovf_q;
  logic                     serr_q;

  logic                     phase_q;
  logic                     href_q;
  logic [DATA_IN_WIDTH-1:0] hi_q;
  logic [CNT_WIDTH-1:0]     x_q;
  logic [CNT_WIDTH-1:0]     y_q;
  logic [PIX_WIDTH-1:0]     pix_q;
  logic                     pix_vld_q;
  logic [ADDR_WIDTH-1:0]    ptr_q;
  logic                     full_q;
  logic [ADDR_WIDTH-1:0]    addr_q;
  logic [PIX_WIDTH-1:0]     dout_q;
  logic                     wr_en_q;

  logic                     start_acc;
  logic                     vs_rise;
  logic                     arm_go;
  logic                     frame_end;
  logic                     cap_ok;
  logic                     keep;
  logic                     ovf_set;
  logic                     serr_set;
  logic [CNT_WIDTH-1:0]     mask;
  logic [15:0]              pix_w;
  logic [PIX_WIDTH-1:0]     pix_fmt;
  logic                     unused_bits;

  // abort has priority over start, so start+abort in IDLE stays in IDLE
  assign start_acc = start && !abort && (state_q == S_IDLE);
  assign vs_rise   = camera_v_sync && !vs_q;
  assign arm_go    = (state_q == S_ARM) && !abort && seen_vs_q && !camera_v_sync;
  assign frame_end = (state_q == S_CAPTURE) && !abort && vs_rise;
  assign cap_ok    = (state_q == S_CAPTURE) && !abort && !camera_v_sync;

  assign pix_w = 16'({hi_q, din});

  generate
    if (PIX_WIDTH == 12) begin : g_rgb444
      assign pix_fmt     = {pix_w[15:12], pix_w[10:7], pix_w[4:1]};
      assign unused_bits = ^{pix_w[11], pix_w[6:5], pix_w[0]};
    end else begin : g_rgb565
      assign pix_fmt     = pix_w[PIX_WIDTH-1:0];
      assign unused_bits = 1'b0;
    end
  endgenerate

  always_comb begin
    mask = '0;
    case (decim_q)
      2'd0:    mask = '0;
      2'd1:    mask = CNT_WIDTH'(1);
      default: mask = CNT_WIDTH'(3);
    endcase
  end

  assign keep     = ((x_q & mask) == '0) && ((y_q & mask) == '0);
  assign ovf_set  = cap_ok && pix_vld_q && full_q;
  assign serr_set = cap_ok && !camera_h_ref && phase_q;

  // FSM: state register
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (start_acc) state_d = S_ARM;
      S_ARM: begin
        if (abort)       state_d = S_IDLE;
        else if (arm_go) state_d = S_CAPTURE;
      end
      S_CAPTURE: begin
        if (abort)          state_d = S_IDLE;
        else if (frame_end) state_d = cont_q ? S_ARM : S_IDLE;
      end
      default:   state_d = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    busy = (state_q != S_IDLE);
  end

  // Control and status. Re-arming from CAPTURE counts the terminating v_sync
  // as the blanking cycle, so a short v_sync pulse still re-arms cleanly.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      vs_q      <= 1'b0;
      seen_vs_q <= 1'b0;
      cont_q    <= 1'b0;
      decim_q   <= 2'd0;
      done_q    <= 1'b0;
      fcnt_q    <= '0;
      ovf_q     <= 1'b0;
      serr_q    <= 1'b0;
    end else begin
      vs_q      <= camera_v_sync;
      seen_vs_q <= (state_d == S_ARM) &&
                   (((state_q == S_ARM) && (seen_vs_q || camera_v_sync)) ||
                    (state_q == S_CAPTURE));
      if (start_acc) begin
        cont_q  <= continuous;
        decim_q <= (decim == 2'd3) ? 2'd2 : decim;
      end
      if (start_acc)      done_q <= 1'b0;
      else if (frame_end) done_q <= 1'b1;
      else if (cont_q)    done_q <= 1'b0;
      if (frame_end) fcnt_q <= fcnt_q + 1'b1;
      if (start_acc)    ovf_q <= 1'b0;
      else if (ovf_set) ovf_q <= 1'b1;
      if (start_acc)     serr_q <= 1'b0;
      else if (serr_set) serr_q <= 1'b1;
    end
  end

  // Capture datapath: stage 1 pairs bytes into a pixel and applies the keep
  // rule; stage 2 assigns the address and drives the write port.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q   <= 1'b0;
      href_q    <= 1'b0;
      hi_q      <= '0;
      x_q       <= '0;
      y_q       <= '0;
      pix_q     <= '0;
      pix_vld_q <= 1'b0;
      ptr_q     <= '0;
      full_q    <= 1'b0;
      addr_q    <= '0;
      dout_q    <= '0;
      wr_en_q   <= 1'b0;
    end else begin
      wr_en_q   <= 1'b0;
      pix_vld_q <= 1'b0;
      if (arm_go) begin
        phase_q <= 1'b0;
        href_q  <= 1'b0;
        x_q     <= '0;
        y_q     <= '0;
        ptr_q   <= '0;
        full_q  <= 1'b0;
        addr_q  <= '0;
      end else if (cap_ok) begin
        href_q <= camera_h_ref;
        if (camera_h_ref) begin
          if (!phase_q) begin
            hi_q    <= din;
            phase_q <= 1'b1;
          end else begin
            phase_q   <= 1'b0;
            pix_q     <= pix_fmt;
            pix_vld_q <= keep;
            if (x_q != '1) x_q <= x_q + 1'b1;
          end
        end else begin
          // an orphan high byte is simply dropped here
          phase_q <= 1'b0;
          if (href_q) begin
            x_q <= '0;
            if (y_q != '1) y_q <= y_q + 1'b1;
          end
        end
        if (pix_vld_q && !full_q) begin
          wr_en_q <= 1'b1;
          addr_q  <= ptr_q;
          dout_q  <= pix_q;
          if (ptr_q == '1) full_q <= 1'b1;
          else             ptr_q  <= ptr_q + 1'b1;
        end
      end else begin
        phase_q <= 1'b0;
        href_q  <= 1'b0;
      end
    end
  end

  assign addr      = addr_q;
  assign dout      = dout_q;
  assign wr_en     = wr_en_q;
  assign done      = done_q;
  assign frame_cnt = fcnt_q;
  assign overflow  = ovf_q;
  assign sync_err  = serr_q;

endmodule
